// File: rtl/i2c_slave_regs_if.sv
// i2c_slave_regs_if: I2C pad signals and local register-port signals of i2c_slave_regs.
interface i2c_slave_regs_if #(parameter int AW = 4);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oen_o;
  logic [AW-1:0] loc_addr_i;
  logic [7:0]    loc_rdata_o;
  logic          wr_valid_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;
  logic          busy_o;
  modport slave (
    input  scl_i, sda_i, loc_addr_i,
    output sda_oen_o, loc_rdata_o, wr_valid_o, wr_addr_o, wr_data_o, busy_o
  );
  modport master (
    output scl_i, sda_i, loc_addr_i,
    input  sda_oen_o, loc_rdata_o, wr_valid_o, wr_addr_o, wr_data_o, busy_o
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C slave exposing NREGS 8-bit registers with an auto-incrementing pointer.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NREGS      = 16
) (
  input logic clk,
  input logic rst_n,
  i2c_slave_regs_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  state_t        r_state;
  logic [1:0]    r_scl_s, r_sda_s;
  logic          r_scl_d, r_sda_d, r_rw, r_oen, r_busy, r_wr_valid;
  logic [2:0]    r_cnt;
  logic [6:0]    r_sh;
  logic [7:0]    r_wr_data;
  logic [AW-1:0] r_ptr, r_wr_addr;
  logic [7:0]    r_regs [NREGS];
  logic          w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_hit;
  logic [7:0]    w_byte, w_next;
  logic [AW-1:0] w_ptr_inc;
  assign w_scl     = r_scl_s[1];
  assign w_sda     = r_sda_s[1];
  assign w_rise    = w_scl & ~r_scl_d;
  assign w_fall    = ~w_scl & r_scl_d;
  assign w_start   = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop    = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte    = {r_sh, w_sda};
  assign w_hit     = w_byte[7:1] == SLAVE_ADDR;
  assign w_ptr_inc = r_ptr + AW'(1);
  assign w_next    = r_regs[w_ptr_inc];
  assign bus.sda_oen_o   = r_oen;
  assign bus.loc_rdata_o = r_regs[bus.loc_addr_i];
  assign bus.wr_valid_o  = r_wr_valid;
  assign bus.wr_addr_o   = r_wr_addr;
  assign bus.wr_data_o   = r_wr_data;
  assign bus.busy_o      = r_busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_scl_s <= 2'b11;
      r_sda_s <= 2'b11;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[0], bus.scl_i};
      r_sda_s <= {r_sda_s[0], bus.sda_i};
      r_scl_d <= r_scl_s[1];
      r_sda_d <= r_sda_s[1];
    end
  // ACK states use r_cnt as a phase: 0 until the fall that starts the ACK bit, then 1 (or 2 once the master ACKed a read)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_rw       <= 1'b0;
      r_oen      <= 1'b1;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_ptr      <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_stop) begin
        r_state <= IDLE;
        r_oen   <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_start) begin
        r_state <= ADDR;
        r_cnt   <= '0;
        r_oen   <= 1'b1;
      end else case (r_state)
        ADDR, PTR, WDATA: if (w_rise) begin
          r_sh  <= w_byte[6:0];
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7 && r_state == ADDR) begin
            r_state <= w_hit ? ADDR_ACK : IGNORE;
            r_busy  <= w_hit;
            r_rw    <= w_byte[0];
          end else if (r_cnt == 3'd7 && r_state == PTR) begin
            r_state <= PTR_ACK;
            r_ptr   <= w_byte[AW-1:0];
          end else if (r_cnt == 3'd7) begin
            r_state        <= WDATA_ACK;
            r_regs[r_ptr]  <= w_byte;
            r_wr_valid     <= 1'b1;
            r_wr_addr      <= r_ptr;
            r_wr_data      <= w_byte;
            r_ptr          <= w_ptr_inc;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_fall && r_cnt == 3'd0) begin
          r_oen <= 1'b0;
          r_cnt <= 3'd1;
        end else if (w_fall) begin
          r_cnt <= '0;
          if (r_state == ADDR_ACK && r_rw) begin
            r_state <= RDATA;
            r_sh    <= r_regs[r_ptr][6:0];
            r_oen   <= r_regs[r_ptr][7];
          end else begin
            r_state <= r_state == ADDR_ACK ? PTR : WDATA;
            r_oen   <= 1'b1;
          end
        end
        RDATA: if (w_rise) begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= RDATA_ACK;
        end else if (w_fall) begin
          r_oen <= r_sh[6];
          r_sh  <= {r_sh[5:0], 1'b0};
        end
        RDATA_ACK: if (w_fall && r_cnt == 3'd0) begin
          r_oen <= 1'b1;
          r_cnt <= 3'd1;
        end else if (w_rise && w_sda) begin
          r_state <= IGNORE;
          r_busy  <= 1'b0;
        end else if (w_rise) begin
          r_cnt <= 3'd2;
        end else if (w_fall && r_cnt == 3'd2) begin
          r_state <= RDATA;
          r_cnt   <= '0;
          r_ptr   <= w_ptr_inc;
          r_sh    <= w_next[6:0];
          r_oen   <= w_next[7];
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: randomized I2C master against a register-file model; a monitor scores write pulses.
module tb_i2c_slave_regs;
  localparam int Q = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mregs [16];
  int mptr = 0;
  logic [7:0] tx [$];
  logic [11:0] exp_q [$];
  logic [11:0] mon_e;
  i2c_slave_regs_if #(.AW(4)) bus();
  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .NREGS(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & bus.sda_oen_o;
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.wr_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", bus.wr_addr_o, bus.wr_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr_o, mon_e[11:8]);
        check("wr_data", bus.wr_data_o, mon_e[7:0]);
      end
    end
  task automatic hq(); repeat (Q) @(negedge clk); endtask
  task automatic i2c_start(); m_sda = 1; hq(); m_scl = 1; hq(); m_sda = 0; hq(); m_scl = 0; hq(); endtask
  task automatic i2c_stop(); m_sda = 0; hq(); m_scl = 1; hq(); m_sda = 1; hq(); endtask
  task automatic clk_bit(input logic b, output logic r);
    m_sda = b; hq(); m_scl = 1; hq(); r = bus.sda_i; hq(); m_scl = 0; hq();
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 0; i < 8; i++) begin clk_bit(1'b1, r); d = {d[6:0], r}; end
    clk_bit(nack, r);
  endtask
  // first byte of tx is the pointer, the rest are data bytes
  task automatic write_txn(input logic [6:0] a, input bit do_stop);
    logic ack;
    bit hit;
    hit = a == 7'h50;
    i2c_start();
    send_byte({a, 1'b0}, ack);
    check("waddr_ack", ack, !hit);
    if (hit) check("busy_addressed", bus.busy_o, 1);
    foreach (tx[i]) begin
      if (hit && i == 0) mptr = tx[i] % 16;
      else if (hit) begin
        mregs[mptr] = tx[i];
        exp_q.push_back({mptr[3:0], tx[i]});
        mptr = (mptr + 1) % 16;
      end
      send_byte(tx[i], ack);
      check("wbyte_ack", ack, !hit);
    end
    if (do_stop) begin i2c_stop(); check("busy_after_stop", bus.busy_o, 0); end
  endtask
  task automatic read_txn(input logic [6:0] a, input int n);
    logic ack;
    logic [7:0] d;
    bit hit;
    hit = a == 7'h50;
    i2c_start();
    send_byte({a, 1'b1}, ack);
    check("raddr_ack", ack, !hit);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      check("rdata", d, hit ? mregs[mptr] : 8'hFF);
      if (hit && i != n - 1) mptr = (mptr + 1) % 16;
    end
    check("sda_released_after_nack", bus.sda_oen_o, 1);
    i2c_stop();
    check("busy_after_stop", bus.busy_o, 0);
  endtask
  task automatic peek(input int a, input int exp, input string name);
    bus.loc_addr_i = 4'(a);
    #1;
    check(name, bus.loc_rdata_o, exp);
  endtask
  initial begin
    logic r;
    logic [6:0] a;
    int kind;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    bus.loc_addr_i = '0;
    repeat (4) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    check("rst_sda_oen", bus.sda_oen_o, 1);
    check("rst_wr_valid", bus.wr_valid_o, 0);
    check("rst_wr_addr", bus.wr_addr_o, 0);
    check("rst_wr_data", bus.wr_data_o, 0);
    check("rst_busy", bus.busy_o, 0);
    peek(0, 0, "rst_reg0");
    tx = '{8'h03, 8'h11, 8'h22};
    write_txn(7'h50, 1);
    peek(4, 8'h22, "reg4_after_write");
    peek(3, 8'h11, "reg3_after_write");
    tx = '{8'h04};
    write_txn(7'h50, 0);
    read_txn(7'h50, 2);
    tx = '{8'h00, 8'h55, 8'h66};
    write_txn(7'h51, 1);
    peek(0, 8'h00, "reg0_after_bad_addr");
    tx = '{8'h0F, 8'hAA, 8'hBB};
    write_txn(7'h50, 1);
    peek(15, 8'hAA, "wrap_reg15");
    peek(0, 8'hBB, "wrap_reg0");
    tx = '{8'h07};
    write_txn(7'h50, 0);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    i2c_stop();
    check("busy_after_midbyte_stop", bus.busy_o, 0);
    peek(7, 8'h00, "reg7_no_partial_write");
    tx = '{8'h07, 8'h5A};
    write_txn(7'h50, 1);
    peek(7, 8'h5A, "reg7_after_recovery");
    tx = '{8'h05, 8'h0F};
    write_txn(7'h50, 1);
    tx = '{8'h05};
    write_txn(7'h50, 0);
    i2c_start();
    send_byte({7'h50, 1'b1}, r);
    check("rst_test_addr_ack", r, 0);
    m_sda = 1; hq(); m_scl = 1; hq();
    check("rst_test_driving_low", bus.sda_oen_o, 0);
    rst_n = 0;
    #1;
    check("rst_releases_sda", bus.sda_oen_o, 1);
    hq(); m_scl = 0; hq();
    rst_n = 1;
    hq(); m_scl = 1; hq();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    for (int i = 0; i < 16; i++) peek(i, 0, "reg_cleared_by_reset");
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      tx.delete();
      case (kind)
        0: begin
          tx.push_back(8'($urandom));
          repeat ($urandom_range(1, 3)) tx.push_back(8'($urandom));
          write_txn(7'h50, 1);
        end
        1: read_txn(7'h50, $urandom_range(1, 3));
        2: begin
          tx.push_back(8'($urandom));
          write_txn(7'h50, 0);
          read_txn(7'h50, $urandom_range(1, 3));
        end
        default: begin
          a = 7'($urandom);
          if (a == 7'h50) a = 7'h51;
          tx.push_back(8'($urandom));
          tx.push_back(8'($urandom));
          write_txn(a, 1);
        end
      endcase
    end
    for (int i = 0; i < 16; i++) peek(i, mregs[i], "final_reg");
    check("pending_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
